// File: rtl/twitchcore_uart_tx.sv
// twitchcore_uart_tx: memory-mapped byte transmitter for the twitchcore data bus.
// Stores to TXDATA queue a byte into a small FIFO; an 8N1 serializer drains it onto o_tx.
//
// Ports:
//   i_clk       single clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_wr_en     bus write strobe (one cycle per store)
//   i_wr_addr   write byte offset: 0x0 TXDATA, 0x4 STATUS (wr_data[3]=1 clears overflow)
//   i_wr_data   store data
//   i_rd_en     bus read strobe
//   i_rd_addr   read byte offset: 0x4 STATUS, everything else reads 0
//   o_rd_data   registered read data, held until the next read
//   o_tx        serial line, idle high, registered
//   o_tx_done   one-cycle pulse as the FSM returns to idle after a stop bit
module twitchcore_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  input  logic        i_rd_en,
  input  logic [3:0]  i_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_tx,
  output logic        o_tx_done
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CntW-1:0]  DepthCnt   = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast   = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       AddrTxData = 4'h0;
  localparam logic [3:0]       AddrStatus = 4'h4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_ovf;

  // Serializer state
  state_e          r_state;
  state_e          w_state_d;
  logic [BaudW-1:0] r_baud;
  logic [BaudW-1:0] w_baud_d;
  logic [3:0]      r_bit_cnt;
  logic [3:0]      w_bit_d;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_d;
  logic            r_tx;
  logic            w_tx_d;
  logic            r_tx_done;
  logic            w_done_d;
  logic [31:0]     r_rd_data;

  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_busy;
  logic w_ovf_clr;
  logic w_baud_last;
  logic [31:0] w_status;
  logic w_unused_wdata;

  assign w_unused_wdata = ^i_wr_data[31:8];

  assign w_full      = (r_count == DepthCnt);
  assign w_empty     = (r_count == '0);
  assign w_busy      = (r_state != StIdle);
  assign w_push_req  = i_wr_en && (i_wr_addr == AddrTxData);
  // Fullness uses the pre-edge count, so a same-cycle pop cannot rescue a push.
  assign w_push      = w_push_req && !w_full;
  assign w_ovf_clr   = i_wr_en && (i_wr_addr == AddrStatus) && i_wr_data[3];
  assign w_baud_last = (r_baud == BaudLast);

  always_comb begin
    w_status      = '0;
    w_status[3:0] = {r_ovf, w_busy, w_empty, w_full};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data[7:0];
  end

  // Transmit FSM state register; o_tx and o_tx_done are registered here too.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_baud    <= w_baud_d;
      r_bit_cnt <= w_bit_d;
      r_shift   <= w_shift_d;
      r_tx      <= w_tx_d;
      r_tx_done <= w_done_d;
    end
  end

  // Next-state logic; w_tx_d is the line level for the cycle after the edge.
  always_comb begin
    w_state_d = r_state;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit_cnt;
    w_shift_d = r_shift;
    w_tx_d    = r_tx;
    w_done_d  = 1'b0;
    w_pop     = 1'b0;
    case (r_state)
      StIdle: begin
        w_tx_d = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = r_mem[r_rd_ptr];
          w_bit_d   = '0;
          w_baud_d  = '0;
          w_state_d = StStart;
          w_tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_state_d = StData;
          w_tx_d    = r_shift[0];
        end else begin
          w_baud_d = r_baud + BaudW'(1);
        end
      end
      StData: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_shift_d = {1'b0, r_shift[7:1]};
          w_bit_d   = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_state_d = StStop;
            w_tx_d    = 1'b1;
          end else begin
            // Next bit is what the shift register will hold at bit 0 after the shift.
            w_tx_d = r_shift[1];
          end
        end else begin
          w_baud_d = r_baud + BaudW'(1);
        end
      end
      StStop: begin
        w_tx_d = 1'b1;
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end else begin
          w_baud_d = r_baud + BaudW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_d    = 1'b1;
      end
    endcase
  end

  // Read port samples pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= (i_rd_addr == AddrStatus) ? w_status : '0;
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_tx      = r_tx;
  assign o_tx_done = r_tx_done;

endmodule

// File: tb/tb_twitchcore_uart_tx.sv
// Bench for twitchcore_uart_tx: a frame-position model predicts o_tx, o_tx_done and o_rd_data
// every cycle; directed scenarios add literal expectations that pin the model.
module tb_twitchcore_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        tx;
  logic        tx_done;

  twitchcore_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_wr_en  (wr_en),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .i_rd_en  (rd_en),
    .i_rd_addr(rd_addr),
    .o_rd_data(rd_data),
    .o_tx     (tx),
    .o_tx_done(tx_done)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pos = cycles since the frame's start bit began (-1 when idle); pos==FRAME is the
  // single idle cycle carrying tx_done.
  logic [7:0]  mq[$];
  logic [7:0]  sent[$];
  logic [7:0]  cur = '0;
  int          pos = -1;
  logic        m_ovf = 1'b0;
  logic [31:0] exp_rd = '0;
  logic        exp_tx = 1'b1;
  logic        exp_done = 1'b0;
  bit          chk_en = 1'b0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      pos    = -1;
      m_ovf  = 1'b0;
      exp_rd = '0;
    end else begin
      int  sz;
      bit  busy;
      sz   = mq.size();
      busy = (pos >= 0) && (pos < FRAME);
      if (rd_en) begin
        exp_rd = '0;
        if (rd_addr == 4'h4) begin
          exp_rd[0] = (sz == DEPTH);
          exp_rd[1] = (sz == 0);
          exp_rd[2] = busy;
          exp_rd[3] = m_ovf;
        end
      end
      if (busy) begin
        pos++;
      end else if (sz > 0) begin
        cur = mq.pop_front();
        sent.push_back(cur);
        pos = 0;
      end else begin
        pos = -1;
      end
      if (wr_en && wr_addr == 4'h0) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else mq.push_back(wr_data[7:0]);
      end
      if (wr_en && wr_addr == 4'h4 && wr_data[3]) m_ovf = 1'b0;
    end
    if (pos < 0)              exp_tx = 1'b1;
    else if (pos < CPB)       exp_tx = 1'b0;
    else if (pos < 9 * CPB)   exp_tx = cur[(pos - CPB) / CPB];
    else                      exp_tx = 1'b1;
    exp_done = (pos == FRAME);
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_tx", {31'b0, tx}, {31'b0, exp_tx});
      check("model_tx_done", {31'b0, tx_done}, {31'b0, exp_done});
      check("model_rd_data", rd_data, exp_rd);
    end
  end

  // Bus helpers: entered and left at 1 time unit after a rising edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  logic [7:0] exp_sent [6] = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11};

  initial begin
    int lows;
    logic exp_bit;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    repeat (20) begin
      @(negedge clk);
      check("idle_tx", {31'b0, tx}, 32'h1);
      check("idle_tx_done", {31'b0, tx_done}, 32'h0);
      check("idle_rd_data", rd_data, 32'h0);
    end
    @(posedge clk); #1;
    bus_read(4'h4);
    check("status_after_reset", rd_data, 32'h2);

    // 0x55 frame, with a same-cycle STATUS read that must see pre-write state
    wr_en = 1'b1; wr_addr = 4'h0; wr_data = 32'h55;
    rd_en = 1'b1; rd_addr = 4'h4;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    check("wr_rd_same_cycle", rd_data, 32'h2);
    for (int k = 1; k <= 41; k++) begin
      @(posedge clk); #1;
      if (k <= 4)       exp_bit = 1'b0;
      else if (k <= 36) exp_bit = (((k - 5) / 4) % 2 == 0);
      else              exp_bit = 1'b1;
      check($sformatf("frame55_tx_k%0d", k), {31'b0, tx}, {31'b0, exp_bit});
      check($sformatf("frame55_done_k%0d", k), {31'b0, tx_done}, {31'b0, (k == 41)});
    end
    repeat (5) @(posedge clk); #1;

    // Burst of eight writes into a depth-4 FIFO: 0x01 is popped, 0x12..0x14 dropped
    for (int i = 0; i < 8; i++) begin
      bus_write(4'h0, (i < 4) ? 32'(i + 1) : 32'(8'h11 + i - 4));
    end
    bus_read(4'h4);
    check("status_burst_full_ovf", rd_data, 32'hD);
    bus_write(4'h4, 32'h8);
    bus_read(4'h4);
    check("status_ovf_cleared", rd_data, 32'h5);
    repeat (5 * (FRAME + 1) + 15) @(posedge clk); #1;
    check("sent_count", 32'(sent.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < sent.size()) check($sformatf("sent_byte%0d", i), {24'b0, sent[i]},
                                 {24'b0, exp_sent[i]});
    end

    // Reset in the middle of an 0xA5 frame with two bytes queued
    bus_write(4'h0, 32'hA5);
    bus_write(4'h0, 32'hB1);
    bus_write(4'h0, 32'hB2);
    repeat (8) @(posedge clk);
    #2;
    check("pre_reset_tx_low", {31'b0, tx}, 32'h0);
    reset = 1'b1;
    #1;
    check("reset_async_tx", {31'b0, tx}, 32'h1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus_read(4'h4);
    check("status_after_mid_reset", rd_data, 32'h2);
    lows = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    check("no_frames_after_reset", 32'(lows), 32'd0);
    @(posedge clk); #1;

    // Upper data bits ignored; unmapped offset reads zero
    bus_write(4'h0, 32'hDEADBE41);
    @(posedge clk); #1;
    bus_read(4'h4);
    check("status_busy_empty", rd_data, 32'h6);
    bus_read(4'hC);
    check("read_unmapped", rd_data, 32'h0);
    repeat (FRAME + 5) @(posedge clk); #1;
    check("dead_byte_serialized", {24'b0, sent[sent.size() - 1]}, 32'h41);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
